// File: rtl/direct_tx_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : direct_pkg
// Description : Shared widths, arbiter state encoding and the AXI-Stream beat
//               bundle used by the direct_tx arbiter and its round-robin
//               picker.
// Revision    : 1.0 - initial release
// ============================================================================
package direct_pkg;

  localparam int DIRECT_DATA_W = 512;
  localparam int DIRECT_KEEP_W = 64;
  localparam int DIRECT_DEST_W = 16;
  localparam int DIRECT_USER_W = 48;

  typedef enum logic [0:0] {
    ARB_IDLE   = 1'b0,
    ARB_LOCKED = 1'b1
  } arb_state_t;

  // One stream beat with every sideband field except the handshake.
  typedef struct packed {
    logic                     tlast;
    logic [DIRECT_DATA_W-1:0] tdata;
    logic [DIRECT_KEEP_W-1:0] tkeep;
    logic [DIRECT_DEST_W-1:0] tdest;
    logic [DIRECT_USER_W-1:0] tuser;
  } axis_beat_t;

endpackage
`default_nettype wire

// File: rtl/direct_tx_arbiter_rr_picker.sv
`default_nettype none
// ============================================================================
// Module      : rr_picker
// Description : Purely combinational round-robin search. Returns the first
//               set request bit found scanning upward from rr_ptr with wrap.
// Ports       : req     - request vector, one bit per source
//               rr_ptr  - index searched first
//               winner  - selected index (0 when nothing is requested)
//               any_req - high when at least one request bit is set
// Revision    : 1.0 - initial release
// ============================================================================
module rr_picker #(
  parameter int NUM_IN = 2,
  parameter int IDX_W  = $clog2(NUM_IN)
) (
  input  logic [NUM_IN-1:0] req,
  input  logic [IDX_W-1:0]  rr_ptr,
  output logic [IDX_W-1:0]  winner,
  output logic              any_req
);

  // One extra bit so rr_ptr + offset never overflows before the wrap.
  logic [IDX_W:0] w_idx;

  // Scan offsets from farthest to nearest: the nearest requester is written
  // last and therefore wins.
  always_comb begin
    winner  = '0;
    any_req = 1'b0;
    w_idx   = '0;
    for (int k = NUM_IN - 1; k >= 0; k--) begin
      w_idx = {1'b0, rr_ptr} + (IDX_W+1)'(k);
      if (w_idx >= (IDX_W+1)'(NUM_IN)) begin
        w_idx = w_idx - (IDX_W+1)'(NUM_IN);
      end
      if (req[w_idx[IDX_W-1:0]]) begin
        winner  = w_idx[IDX_W-1:0];
        any_req = 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/direct_tx_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : direct_tx_arbiter
// Description : Packet-granular round-robin merge of NUM_IN AXI-Stream sources
//               onto the direct_tx stream. A grant is held until the owner's
//               tlast beat is accepted, so packets never interleave.
// Ports       : clk, rst           - clock, asynchronous active-high reset
//               in_*               - flattened per-source streams
//               direct_tx_*        - merged output stream
//               grant_idx          - current or most recent owner
//               busy               - high while a packet is locked
// Build macro : DIRECT_ARB_OUTREG_EN - inserts a 2-entry skid buffer on the
//               direct_tx side (all outputs and the ready path registered,
//               +1 cycle latency, full throughput).
// Revision    : 1.0 - initial release
// ============================================================================
module direct_tx_arbiter
  import direct_pkg::*;
#(
  parameter int NUM_IN = 2,
  parameter int IDX_W  = $clog2(NUM_IN)
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [NUM_IN-1:0]                 in_tvalid,
  output logic [NUM_IN-1:0]                 in_tready,
  input  logic [NUM_IN-1:0]                 in_tlast,
  input  logic [NUM_IN*DIRECT_DATA_W-1:0]   in_tdata,
  input  logic [NUM_IN*DIRECT_KEEP_W-1:0]   in_tkeep,
  input  logic [NUM_IN*DIRECT_DEST_W-1:0]   in_tdest,
  input  logic [NUM_IN*DIRECT_USER_W-1:0]   in_tuser,
  output logic                              direct_tx_tvalid,
  input  logic                              direct_tx_tready,
  output logic                              direct_tx_tlast,
  output logic [DIRECT_DATA_W-1:0]          direct_tx_tdata,
  output logic [DIRECT_KEEP_W-1:0]          direct_tx_tkeep,
  output logic [DIRECT_DEST_W-1:0]          direct_tx_tdest,
  output logic [DIRECT_USER_W-1:0]          direct_tx_tuser,
  output logic [IDX_W-1:0]                  grant_idx,
  output logic                              busy
);

  arb_state_t       r_state;
  arb_state_t       w_state_next;
  logic [IDX_W-1:0] r_grant_idx;
  logic [IDX_W-1:0] r_rr_ptr;
  logic [IDX_W-1:0] w_winner;
  logic [IDX_W-1:0] w_ptr_after;
  logic             w_any_req;
  logic             w_src_valid;
  logic             w_m_valid;
  logic             w_m_ready;
  logic             w_m_done;
  axis_beat_t       w_src_beat;
  axis_beat_t       w_m_beat;

  rr_picker #(
    .NUM_IN (NUM_IN),
    .IDX_W  (IDX_W)
  ) u_rr_picker (
    .req     (in_tvalid),
    .rr_ptr  (r_rr_ptr),
    .winner  (w_winner),
    .any_req (w_any_req)
  );

  // Select the granted source's beat out of the flattened input buses.
  always_comb begin
    w_src_valid = 1'b0;
    w_src_beat  = '0;
    for (int i = 0; i < NUM_IN; i++) begin
      if (IDX_W'(i) == r_grant_idx) begin
        w_src_valid      = in_tvalid[i];
        w_src_beat.tlast = in_tlast[i];
        w_src_beat.tdata = in_tdata[i*DIRECT_DATA_W +: DIRECT_DATA_W];
        w_src_beat.tkeep = in_tkeep[i*DIRECT_KEEP_W +: DIRECT_KEEP_W];
        w_src_beat.tdest = in_tdest[i*DIRECT_DEST_W +: DIRECT_DEST_W];
        w_src_beat.tuser = in_tuser[i*DIRECT_USER_W +: DIRECT_USER_W];
      end
    end
  end

  assign w_ptr_after = (r_grant_idx == IDX_W'(NUM_IN - 1)) ? '0
                                                            : r_grant_idx + IDX_W'(1);
  // Packet ends when its tlast beat leaves the arbiter (into the output
  // stream or, with the skid buffer, into the buffer).
  assign w_m_done    = w_m_valid && w_m_ready && w_m_beat.tlast;
  assign grant_idx   = r_grant_idx;

  // State register, grant capture and round-robin pointer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= ARB_IDLE;
      r_grant_idx <= '0;
      r_rr_ptr    <= '0;
    end else begin
      r_state <= w_state_next;
      if ((r_state == ARB_IDLE) && w_any_req) begin
        r_grant_idx <= w_winner;
      end
      if (w_m_done) begin
        r_rr_ptr <= w_ptr_after;
      end
    end
  end

  // Next-state logic.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ARB_IDLE:   if (w_any_req) w_state_next = ARB_LOCKED;
      ARB_LOCKED: if (w_m_done)  w_state_next = ARB_IDLE;
      default:    w_state_next = ARB_IDLE;
    endcase
  end

  // Output logic: pass-through of the owner while locked, all quiet in IDLE.
  always_comb begin
    busy      = (r_state == ARB_LOCKED);
    w_m_valid = busy && w_src_valid;
    w_m_beat  = busy ? w_src_beat : '0;
    in_tready = '0;
    for (int i = 0; i < NUM_IN; i++) begin
      if (busy && (IDX_W'(i) == r_grant_idx)) begin
        in_tready[i] = w_m_ready;
      end
    end
  end

`ifdef DIRECT_ARB_OUTREG_EN
  // Two-entry skid buffer: r_out holds the presented beat, r_skid catches the
  // one beat accepted in the cycle downstream stalls. Upstream ready depends
  // only on the skid occupancy, so the ready path is registered.
  axis_beat_t r_out_beat;
  axis_beat_t r_skid_beat;
  logic       r_out_valid;
  logic       r_skid_valid;

  assign w_m_ready = !r_skid_valid;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_out_valid  <= 1'b0;
      r_skid_valid <= 1'b0;
      r_out_beat   <= '0;
      r_skid_beat  <= '0;
    end else if (r_skid_valid) begin
      if (direct_tx_tready) begin
        r_out_beat   <= r_skid_beat;
        r_skid_valid <= 1'b0;
      end
    end else if (w_m_valid) begin
      if (!r_out_valid || direct_tx_tready) begin
        r_out_beat  <= w_m_beat;
        r_out_valid <= 1'b1;
      end else begin
        r_skid_beat  <= w_m_beat;
        r_skid_valid <= 1'b1;
      end
    end else if (direct_tx_tready) begin
      r_out_valid <= 1'b0;
    end
  end

  assign direct_tx_tvalid = r_out_valid;
  assign direct_tx_tlast  = r_out_beat.tlast;
  assign direct_tx_tdata  = r_out_beat.tdata;
  assign direct_tx_tkeep  = r_out_beat.tkeep;
  assign direct_tx_tdest  = r_out_beat.tdest;
  assign direct_tx_tuser  = r_out_beat.tuser;
`else
  assign w_m_ready        = direct_tx_tready;
  assign direct_tx_tvalid = w_m_valid;
  assign direct_tx_tlast  = w_m_beat.tlast;
  assign direct_tx_tdata  = w_m_beat.tdata;
  assign direct_tx_tkeep  = w_m_beat.tkeep;
  assign direct_tx_tdest  = w_m_beat.tdest;
  assign direct_tx_tuser  = w_m_beat.tuser;
`endif

endmodule
`default_nettype wire

// File: doc/direct_tx_arbiter.md
Name: direct_tx_arbiter

Overview:
- Packet-granular round-robin arbiter that merges NUM_IN AXI-Stream sources onto the single direct_tx output stream of the direct-path handler (512-bit data, 16-bit tdest, 48-bit tuser).
- Once a source is granted, it keeps the grant until its tlast beat handshakes, so packets never interleave.
- Sits between local producers (kernel bridges, the direct handler's own control source) and the network-facing direct_tx port.

Parameters:
- NUM_IN, 2, number of requesting sources; legal range 2..8.
- IDX_W, $clog2(NUM_IN), width of the grant index.

Ports:
- clk  in  1  single clock for all logic.
- rst  in  1  reset; asynchronous, active-high.
- in_tvalid  in  NUM_IN  per-source valid.
- in_tready  out  NUM_IN  per-source ready.
- in_tlast  in  NUM_IN  per-source last.
- in_tdata  in  NUM_IN*512  flattened data; source i occupies [i*512 +: 512].
- in_tkeep  in  NUM_IN*64  flattened keep.
- in_tdest  in  NUM_IN*16  flattened dest.
- in_tuser  in  NUM_IN*48  flattened user.
- direct_tx_tvalid  out  1  merged valid.
- direct_tx_tready  in  1  downstream ready.
- direct_tx_tlast  out  1  merged last.
- direct_tx_tdata  out  512  merged data.
- direct_tx_tkeep  out  64  merged keep.
- direct_tx_tdest  out  16  merged dest.
- direct_tx_tuser  out  48  merged user.
- grant_idx  out  IDX_W  index of the current or last owner.
- busy  out  1  high while in LOCKED.

Behaviour:
- Reset (async assert, synchronous release): state=IDLE, rr_ptr=0, grant_idx=0. direct_tx_tvalid=0, in_tready=0, busy=0. Data outputs are don't-care, but are driven to 0 in IDLE.
- State IDLE:
  - in_tready all 0; direct_tx_tvalid=0.
  - If any in_tvalid is set, choose the first set bit searching upward from rr_ptr with wrap (rr_ptr, rr_ptr+1, ..., NUM_IN-1, 0, ...).
  - Register the winner in grant_idx and go to LOCKED on the next edge.
  - If no in_tvalid is set, stay in IDLE.
- State LOCKED:
  - Combinational pass-through of the granted source: direct_tx_* = in_*[grant_idx]; in_tready[grant_idx] = direct_tx_tready; all other in_tready = 0.
  - busy=1.
  - The granted source may drop tvalid mid-packet; the grant is held with no timeout.
- LOCKED -> IDLE only on direct_tx_tvalid && direct_tx_tready && direct_tx_tlast. On that edge rr_ptr = grant_idx+1, wrapping to 0 at NUM_IN.
- Latency:
  - First beat of a packet reaches the output 1 cycle after the source asserts tvalid while the arbiter is in IDLE.
  - Subsequent beats have 0 latency.
  - One idle bubble cycle between back-to-back packets.
- A single-beat packet (tlast on beat 1) is legal: LOCKED for exactly one handshake cycle, then IDLE.
- A tlast beat with direct_tx_tready=0 holds LOCKED until it handshakes.
- A requester that is valid while another source owns the grant waits; starvation is bounded to NUM_IN-1 packets.
- An rst assertion mid-packet forces IDLE immediately (async). The partial packet is dropped from the arbiter's view, and the sources are responsible for recovery.
- tvalid from non-granted sources never affects the outputs.

Optional Feature:
- Macro DIRECT_ARB_OUTREG_EN.
- Defined:
  - A 2-entry skid buffer is inserted on the direct_tx side, giving full registered timing on every output and on the ready path.
  - Output latency becomes +1 cycle; throughput stays 1 beat/cycle.
  - The LOCKED->IDLE transition triggers on the tlast beat being accepted into the skid buffer, not on the downstream handshake.
  - The skid buffer clears on rst.
- Undefined: the combinational pass-through described above.

Decomposition:
- Package direct_pkg holds:
  - DIRECT_DATA_W=512, DIRECT_KEEP_W=64, DIRECT_DEST_W=16, DIRECT_USER_W=48.
  - The state enum arb_state_t {ARB_IDLE, ARB_LOCKED}.
- One sub-module, rr_picker: purely combinational. Inputs are the request vector and rr_ptr; outputs are the winner index and any_req.
- The skid buffer is inlined under the macro.

Test Plan:
- Single packet: NUM_IN=2, source 0 sends 3 beats (tdest=0x0005, tuser=0x123456789ABC), direct_tx_tready=1 -> 3 output beats starting 1 cycle after tvalid, fields unchanged, tlast on beat 3, then IDLE.
- Simultaneous request: sources 0 and 1 each assert 2-beat packets at t=0, each resending immediately -> output packet order 0,1,0,1; one bubble between packets; in_tready[1]=0 throughout source 0's packets.
- Backpressure: direct_tx_tready toggles 1,0,1,0 during a 4-beat packet -> no beat lost or duplicated; the tlast beat held with tready=0 keeps busy=1 until it handshakes.
- Source gap: granted source drops tvalid for 5 cycles mid-packet while source 1 is valid -> grant held, no source-1 data emitted until source 0's tlast.
- Reset mid-packet: assert rst on beat 2 of 4 -> same cycle direct_tx_tvalid=0, in_tready=0, busy=0; after release, a fresh request from source 1 is granted with rr_ptr=0 order.
- DIRECT_ARB_OUTREG_EN build: same stimulus as the simultaneous-request test -> identical beat sequence delayed by 1 cycle; 1 beat/cycle sustained within a packet under constant tready.
